// File: rtl/btn_pkg.sv
// Shared types, timing defaults and helpers for the push-button conditioner.
package btn_pkg;

  // Per-channel conditioning state.
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } btn_state_e;

  // Default timing for a 10 MHz system clock.
  localparam int unsigned DEF_N_BTN           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 512;        // ~51 us
  localparam int unsigned DEF_REPEAT_DELAY    = 5_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_RATE     = 2_000_000;  // 0.2 s

  // Counter width: one spare bit above the largest terminal count so the
  // saturating hold counter never aliases onto a compare value.
  function automatic int unsigned cnt_width(input int unsigned deb,
                                            input int unsigned dly,
                                            input int unsigned rate);
    int unsigned m;
    m = deb;
    if (dly > m)  m = dly;
    if (rate > m) m = rate;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce/auto-repeat state
// machine and a shared counter. Outputs are registered.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press,
  output logic level
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  localparam bit            RPT_EN        = (REPEAT_DELAY != 0);
  localparam logic [CW-1:0] ONE           = CW'(1);
  localparam logic [CW-1:0] DEB_LAST      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RPT_DLY_LAST  = RPT_EN ? CW'(REPEAT_DELAY - 1) : '0;
  localparam logic [CW-1:0] RPT_RATE_LAST = CW'(REPEAT_RATE - 1);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_e    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          press_d;
  logic          level_d;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign s = sync_q[1];

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      press <= press_d;
      level <= level_d;
    end
  end

  // Next-state, counter and output decode; decisions use the synchronised level only.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    press_d = 1'b0;
    level_d = level;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_d = DEB_PRESS;
          cnt_d   = ONE;
        end
      end

      DEB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt + ONE;
        end
      end

      HELD: begin
        if (!s) begin
          state_d = DEB_RELEASE;
          cnt_d   = ONE;
        end else if (RPT_EN && (cnt == RPT_DLY_LAST)) begin
          state_d = REPEAT;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (RPT_EN || (cnt != '1)) begin
          // With auto-repeat disabled the counter parks at all-ones.
          cnt_d = cnt + ONE;
        end
      end

      REPEAT: begin
        if (!s) begin
          state_d = DEB_RELEASE;
          cnt_d   = ONE;
        end else if (cnt == RPT_RATE_LAST) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt + ONE;
        end
      end

      DEB_RELEASE: begin
        if (s) begin
          // Release bounce: back to held without a pulse, repeat delay restarts.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN push-buttons into debounced levels and single-cycle
// press / auto-repeat pulses. Channels are fully independent.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] level,
  output logic             any_held
);

  // One conditioning channel per button.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw[i]),
      .press   (press[i]),
      .level   (level[i])
    );
  end

  // Combinational OR of the registered debounced levels.
  always_comb begin
    any_held = |level;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing parameters.
// Cycle k is the interval after clock edge k; outputs are sampled 1 ns
// after the edge and inputs are driven right after sampling.
module tb_btn_conditioner;

  localparam int unsigned N   = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RR  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] press;
  logic [N-1:0] level;
  logic         any_held;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct packed {
    logic [3:0] btn;        // driven after sampling cycle k
    logic [3:0] exp_press;  // expected in cycle k
    logic [3:0] exp_level;
    logic       exp_any;
  } vec_t;

  vec_t tbl [18];

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .press    (press),
    .level    (level),
    .any_held (any_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int k,
                       input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, k, act, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int cycles);
    btn_raw = '0;
    repeat (cycles) next_edge();
    check("idle_level", -1, level, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    // ch0 clean press, ch1 bounce train (1,1,0 x5), ch3 release bounce 0/1/0.
    tbl[0]  = '{4'hb, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'hb, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'h9, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'hb, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{4'hb, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{4'h9, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{4'hb, 4'h9, 4'h9, 1'b1};
    tbl[7]  = '{4'hb, 4'h0, 4'h9, 1'b1};
    tbl[8]  = '{4'h0, 4'h0, 4'h9, 1'b1};
    tbl[9]  = '{4'ha, 4'h0, 4'h9, 1'b1};
    tbl[10] = '{4'h2, 4'h0, 4'h9, 1'b1};
    tbl[11] = '{4'h0, 4'h0, 4'h9, 1'b1};
    tbl[12] = '{4'h2, 4'h0, 4'h9, 1'b1};
    tbl[13] = '{4'h2, 4'h0, 4'h9, 1'b1};
    tbl[14] = '{4'h0, 4'h0, 4'h8, 1'b1};
    tbl[15] = '{4'h0, 4'h0, 4'h8, 1'b1};
    tbl[16] = '{4'h0, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{4'h0, 4'h0, 4'h0, 1'b0};

    // Reset state.
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) next_edge();
    check("rst_press", 0, press, 4'b0000);
    check("rst_level", 0, level, 4'b0000);
    check("rst_any",   0, {3'b000, any_held}, 4'b0000);
    reset = 1'b0;
    go_idle(5);

    // Clean press / bounce rejection / release bounce, table driven.
    for (int k = 0; k < 18; k++) begin
      next_edge();
      check("tbl_press", k, press, tbl[k].exp_press);
      check("tbl_level", k, level, tbl[k].exp_level);
      check("tbl_any",   k, {3'b000, any_held}, {3'b000, tbl[k].exp_any});
      btn_raw = tbl[k].btn;
    end
    go_idle(20);

    // Auto-repeat on ch2: held 30 cycles.
    for (int k = 0; k <= 40; k++) begin
      logic [3:0] ep;
      logic [3:0] el;
      next_edge();
      ep = (k == 6 || k == 16 || k == 19 || k == 22 || k == 25 || k == 28 || k == 31)
           ? 4'b0100 : 4'b0000;
      el = (k >= 6 && k <= 35) ? 4'b0100 : 4'b0000;
      check("rpt_press", k, press, ep);
      check("rpt_level", k, level, el);
      btn_raw = (k < 30) ? 4'b0100 : 4'b0000;
    end
    go_idle(20);

    // Simultaneous press, then reset while held.
    for (int k = 0; k <= 8; k++) begin
      next_edge();
      check("sim_press", k, press, (k == 6) ? 4'b1111 : 4'b0000);
      check("sim_level", k, level, (k >= 6) ? 4'b1111 : 4'b0000);
      btn_raw = 4'b1111;
    end
    #2 reset = 1'b1;
    #1;
    check("arst_press", 8, press, 4'b0000);
    check("arst_level", 8, level, 4'b0000);
    check("arst_any",   8, {3'b000, any_held}, 4'b0000);
    next_edge();
    check("inrst_press", 9, press, 4'b0000);
    next_edge();
    #2 reset = 1'b0;
    #1;
    check("deassert_press", 10, press, 4'b0000);
    check("deassert_level", 10, level, 4'b0000);
    for (int k = 11; k <= 24; k++) begin
      next_edge();
      check("post_rst_press", k, press, (k == 16) ? 4'b1111 : 4'b0000);
      check("post_rst_level", k, level, (k >= 16) ? 4'b1111 : 4'b0000);
    end
    go_idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
